// File: rtl/icache_direct_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icache_direct_pkg                                                    |
// | Shared defaults and FSM state encoding for the direct-mapped I-cache |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package icache_direct_pkg;

  localparam int ICACHE_IDX_BITS = 6;
  localparam int ICACHE_ADDR_W   = 32;
  localparam int ICACHE_DATA_W   = 32;

  typedef enum logic [1:0] {
    IC_IDLE  = 2'd0,
    IC_MISS  = 2'd1,
    IC_DRAIN = 2'd2
  } ic_state_t;

endpackage
`default_nettype wire

// File: rtl/icache_direct_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icache_array                                                         |
// | Valid/tag/data storage: one combinational read port, one write port  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module icache_array
  import icache_direct_pkg::*;
#(
  parameter int IDX_BITS = ICACHE_IDX_BITS,
  parameter int TAG_W    = ICACHE_ADDR_W - 2 - ICACHE_IDX_BITS,
  parameter int DATA_W   = ICACHE_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] i_rd_idx,
  output logic                o_rd_valid,
  output logic [TAG_W-1:0]    o_rd_tag,
  output logic [DATA_W-1:0]   o_rd_data,
  input  logic                i_we,
  input  logic [IDX_BITS-1:0] i_wr_idx,
  input  logic [TAG_W-1:0]    i_wr_tag,
  input  logic [DATA_W-1:0]   i_wr_data
);

  localparam int DEPTH = 1 << IDX_BITS;

  logic [DEPTH-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  // Only the valid bits need reset; stale tag/data are masked by valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/icache_direct.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icache_direct                                                        |
// | Direct-mapped one-word-line I-cache with single outstanding refill   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int IDX_BITS = ICACHE_IDX_BITS,
  parameter int ADDR_W   = ICACHE_ADDR_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  output logic              if_valid,
  output logic [31:0]       if_ins,
  output logic              mem_need,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_ins
);

  localparam int TAG_W = ADDR_W - 2 - IDX_BITS;

  ic_state_t           r_state;
  logic [TAG_W-1:0]    r_miss_tag;
  logic [IDX_BITS-1:0] r_miss_idx;
  logic                r_if_valid;
  logic [31:0]         r_if_ins;
  logic                r_mem_need;
  logic [ADDR_W-1:0]   r_mem_addr;

  logic [IDX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_rd_valid;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [31:0]         w_rd_data;
  logic                w_hit;
  logic                w_fill;
  logic                w_unused;

  assign w_idx    = if_addr[IDX_BITS+1:2];
  assign w_tag    = if_addr[ADDR_W-1:IDX_BITS+2];
  assign w_unused = ^if_addr[1:0];
  assign w_hit    = w_rd_valid && (w_rd_tag == w_tag);
  // A returning word always fills, even after a flush, so the line is not lost.
  assign w_fill   = rdy_in && mem_ready && (r_state != IC_IDLE);

  icache_array #(
    .IDX_BITS (IDX_BITS),
    .TAG_W    (TAG_W),
    .DATA_W   (32)
  ) u_array (
    .clk        (clk_in),
    .rst        (rst_in),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_we       (w_fill),
    .i_wr_idx   (r_miss_idx),
    .i_wr_tag   (r_miss_tag),
    .i_wr_data  (mem_ins)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= IC_IDLE;
      r_miss_tag <= '0;
      r_miss_idx <= '0;
      r_if_valid <= 1'b0;
      r_if_ins   <= '0;
      r_mem_need <= 1'b0;
      r_mem_addr <= '0;
    end else if (rdy_in) begin
      r_if_valid <= 1'b0;
      case (r_state)
        IC_IDLE: begin
          if (!flush && if_req) begin
            if (w_hit) begin
              r_if_valid <= 1'b1;
              r_if_ins   <= w_rd_data;
            end else begin
              r_miss_tag <= w_tag;
              r_miss_idx <= w_idx;
              r_mem_addr <= {if_addr[ADDR_W-1:2], 2'b00};
              r_mem_need <= 1'b1;
              r_state    <= IC_MISS;
            end
          end
        end
        IC_MISS: begin
          if (mem_ready) begin
            r_mem_need <= 1'b0;
            r_state    <= IC_IDLE;
            if (!flush) begin
              r_if_valid <= 1'b1;
              r_if_ins   <= mem_ins;
            end
          end else if (flush) begin
            r_state <= IC_DRAIN;
          end
        end
        IC_DRAIN: begin
          if (mem_ready) begin
            r_mem_need <= 1'b0;
            r_state    <= IC_IDLE;
          end
        end
        default: r_state <= IC_IDLE;
      endcase
    end
  end

  assign if_valid = r_if_valid;
  assign if_ins   = r_if_ins;
  assign mem_need = r_mem_need;
  assign mem_addr = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_icache_direct                                                     |
// | Directed vector bench with a fixed-latency memory controller model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_icache_direct;

  localparam int LAT = 5;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_ins;
  logic        mem_need;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_ins;

  int n_checks = 0;
  int n_pass   = 0;

  icache_direct dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .flush     (flush),
    .if_valid  (if_valid),
    .if_ins    (if_ins),
    .mem_need  (mem_need),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_ins   (mem_ins)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'h0000_0013;
      32'h0000_1100: return 32'h0010_0093;
      32'h0000_2000: return 32'h0000_0113;
      32'h0000_2004: return 32'h0000_0193;
      32'h0000_2008: return 32'h0000_0213;
      32'h0000_3000: return 32'hDEAD_BEEF;
      32'h0000_4000: return 32'h0000_4013;
      32'h0000_5000: return 32'h0000_5513;
      32'h0000_6000: return 32'h0000_6613;
      32'h0000_7000: return 32'h0000_7713;
      default:       return 32'h0BAD_0BAD;
    endcase
  endfunction

  // Memory controller: LAT cycles of mem_need, one-cycle mem_ready, then one stall cycle.
  bit m_rdy;
  int m_cnt;
  bit m_stall;
  always @(posedge clk_in) begin
    m_rdy = rdy_in;
    #1;
    if (rst_in) begin
      mem_ready = 1'b0;
      m_cnt     = 0;
      m_stall   = 1'b0;
    end else if (m_rdy) begin
      if (mem_ready) begin
        mem_ready = 1'b0;
        m_stall   = 1'b1;
      end else if (m_stall) begin
        m_stall = 1'b0;
      end else if (mem_need) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == LAT) begin
          mem_ready = 1'b1;
          mem_ins   = mem_word(mem_addr);
          m_cnt     = 0;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp_ins,
                       input bit exp_miss, input string nm);
    int          cyc;
    bit          saw_need;
    bit          got;
    logic [31:0] need_addr;
    cyc = 0; saw_need = 0; got = 0; need_addr = '0;
    if_req  = 1'b1;
    if_addr = a;
    while (!got && cyc < 60) begin
      tick();
      cyc++;
      if (mem_need) begin
        saw_need  = 1'b1;
        need_addr = mem_addr;
      end
      if (if_valid) got = 1'b1;
    end
    if_req = 1'b0;
    check({nm, " if_valid"}, 32'(got), 32'd1);
    check({nm, " if_ins"}, if_ins, exp_ins);
    check({nm, " missed"}, 32'(saw_need), 32'(exp_miss));
    if (exp_miss) begin
      check({nm, " mem_addr"}, need_addr, {a[31:2], 2'b00});
      check({nm, " mem_need low"}, 32'(mem_need), 32'd0);
    end else begin
      check({nm, " hit latency"}, 32'(cyc), 32'd1);
    end
  endtask

  task automatic wait_need(input string nm);
    int c;
    c = 0;
    while (!mem_need && c < 20) begin tick(); c++; end
    check({nm, " mem_need raised"}, 32'(mem_need), 32'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ins;
    bit          miss;
  } vec_t;

  initial begin
    vec_t        vecs[8];
    logic [31:0] stream_a[3];
    logic [31:0] stream_d[3];
    int          c;
    int          rises;
    bit          got;
    bit          bad;
    bit          prev_need;
    logic [31:0] last_addr;

    vecs[0] = '{32'h0000_1000, 32'h0000_0013, 1'b1};
    vecs[1] = '{32'h0000_1000, 32'h0000_0013, 1'b0};
    vecs[2] = '{32'h0000_1100, 32'h0010_0093, 1'b1};
    vecs[3] = '{32'h0000_1000, 32'h0000_0013, 1'b1};
    vecs[4] = '{32'h0000_1100, 32'h0010_0093, 1'b1};
    vecs[5] = '{32'h0000_2000, 32'h0000_0113, 1'b1};
    vecs[6] = '{32'h0000_2004, 32'h0000_0193, 1'b1};
    vecs[7] = '{32'h0000_2008, 32'h0000_0213, 1'b1};
    stream_a[0] = 32'h0000_2000; stream_d[0] = 32'h0000_0113;
    stream_a[1] = 32'h0000_2004; stream_d[1] = 32'h0000_0193;
    stream_a[2] = 32'h0000_2008; stream_d[2] = 32'h0000_0213;

    rst_in = 1'b1; rdy_in = 1'b1; if_req = 1'b0; if_addr = '0; flush = 1'b0;
    mem_ready = 1'b0; mem_ins = '0;
    repeat (2) tick();
    rst_in = 1'b0;
    check("reset if_valid", 32'(if_valid), 32'd0);
    check("reset if_ins", if_ins, 32'd0);
    check("reset mem_need", 32'(mem_need), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    tick();

    for (int i = 0; i < 8; i++) begin
      fetch(vecs[i].addr, vecs[i].ins, vecs[i].miss, $sformatf("vec%0d", i));
      tick();
    end

    // Second pass over the stream: one hit per cycle.
    if_req = 1'b1; if_addr = stream_a[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stream%0d if_valid", i), 32'(if_valid), 32'd1);
      check($sformatf("stream%0d if_ins", i), if_ins, stream_d[i]);
      check($sformatf("stream%0d mem_need", i), 32'(mem_need), 32'd0);
      if (i < 2) if_addr = stream_a[i+1];
      else if_req = 1'b0;
    end
    tick();

    // Flush two cycles into a miss: line still fills, nothing returned.
    if_req = 1'b1; if_addr = 32'h0000_3000;
    wait_need("flushmiss");
    tick(); tick();
    flush = 1'b1; if_req = 1'b0;
    tick();
    flush = 1'b0;
    c = 0; got = 0; bad = 0;
    while (mem_need && c < 20) begin
      if (mem_addr !== 32'h0000_3000) bad = 1'b1;
      tick(); c++;
      if (if_valid) got = 1'b1;
    end
    check("flushmiss drained", 32'(mem_need), 32'd0);
    check("flushmiss no if_valid", 32'(got), 32'd0);
    check("flushmiss mem_addr stable", 32'(bad), 32'd0);
    check("flushmiss held until data", 32'(c >= 2), 32'd1);
    tick();
    fetch(32'h0000_3000, 32'hDEAD_BEEF, 1'b0, "flushmiss refetch");
    tick();

    // Flush in the same cycle as mem_ready.
    if_req = 1'b1; if_addr = 32'h0000_5000;
    c = 0;
    while (!mem_ready && c < 20) begin tick(); c++; end
    check("coinc mem_ready seen", 32'(mem_ready), 32'd1);
    flush = 1'b1; if_req = 1'b0;
    tick();
    flush = 1'b0;
    check("coinc if_valid", 32'(if_valid), 32'd0);
    check("coinc mem_need", 32'(mem_need), 32'd0);
    tick();
    check("coinc if_valid late", 32'(if_valid), 32'd0);
    fetch(32'h0000_5000, 32'h0000_5513, 1'b0, "coinc refetch");
    tick();

    // New request arrives while draining: serviced only after the drain.
    if_req = 1'b1; if_addr = 32'h0000_6000;
    wait_need("drain");
    flush = 1'b1; if_addr = 32'h0000_4000;
    tick();
    flush = 1'b0;
    c = 0; got = 0; bad = 0; rises = 0; prev_need = 1'b1; last_addr = '0;
    while (!got && c < 40) begin
      if (!prev_need && mem_need) begin rises++; last_addr = mem_addr; end
      if (mem_need && rises == 0 && mem_addr !== 32'h0000_6000) bad = 1'b1;
      if (if_valid) got = 1'b1;
      else begin prev_need = mem_need; tick(); c++; end
    end
    if_req = 1'b0;
    check("drain new fetch valid", 32'(got), 32'd1);
    check("drain new fetch ins", if_ins, 32'h0000_4013);
    check("drain new request count", 32'(rises), 32'd1);
    check("drain new mem_addr", last_addr, 32'h0000_4000);
    check("drain old mem_addr stable", 32'(bad), 32'd0);
    tick();

    // Freeze with mem_ready pending: nothing moves until rdy_in returns.
    if_req = 1'b1; if_addr = 32'h0000_7000;
    c = 0;
    while (!mem_ready && c < 20) begin tick(); c++; end
    rdy_in = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!mem_need || mem_addr !== 32'h0000_7000 || if_valid || !mem_ready) bad = 1'b1;
    end
    check("freeze outputs held", 32'(bad), 32'd0);
    rdy_in = 1'b1;
    tick();
    if_req = 1'b0;
    check("freeze resume if_valid", 32'(if_valid), 32'd1);
    check("freeze resume if_ins", if_ins, 32'h0000_7713);
    check("freeze resume mem_need", 32'(mem_need), 32'd0);
    tick();

    // Asynchronous reset mid-miss.
    if_req = 1'b1; if_addr = 32'h0000_1000;
    wait_need("areset");
    tick();
    #3;
    rst_in = 1'b1;
    #1;
    check("areset mem_need", 32'(mem_need), 32'd0);
    check("areset mem_addr", mem_addr, 32'd0);
    check("areset if_ins", if_ins, 32'd0);
    check("areset if_valid", 32'(if_valid), 32'd0);
    if_req = 1'b0;
    tick();
    rst_in = 1'b0;
    tick();
    fetch(32'h0000_2004, 32'h0000_0193, 1'b1, "post-reset 2004");
    tick();
    fetch(32'h0000_1000, 32'h0000_0013, 1'b1, "post-reset 1000");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
